// File: rtl/conv_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv_mem_pkg                                                         |
// | Memory-operation encodings and responder state type shared with the |
// | convolution processor control store.                                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package conv_mem_pkg;

  localparam logic [2:0] MEM_IDLE  = 3'b000;
  localparam logic [2:0] MEM_WRITE = 3'b001;
  localparam logic [2:0] MEM_READ  = 3'b010;
  localparam logic [2:0] MEM_FETCH = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } resp_state_t;

  function automatic logic is_mem_op(input logic [2:0] cmd);
    return (cmd == MEM_FETCH) || (cmd == MEM_READ) || (cmd == MEM_WRITE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sp_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sp_ram                                                               |
// | Single-port synchronous RAM with registered, enable-qualified read. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sp_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4096,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;

  // Array contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (re) begin
      r_q <= r_mem[addr];
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_responder                                                        |
// | Services fetch/read/write control words from an internal RAM with   |
// | programmable wait states; host preload port while idle.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_responder
  import conv_mem_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        mem_cmd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              is_fetch,
  output logic              wdone,
  output logic              busy,
  output logic              err,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack
);

  localparam int              c_idx_w     = $clog2(DEPTH);
  localparam logic [ADDR_W:0] c_depth     = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      c_wait_load = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  resp_state_t       r_state;
  logic [2:0]        r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_wait_cnt;
  logic              r_rvalid;
  logic              r_is_fetch;
  logic              r_wdone;
  logic              r_busy;
  logic              r_err;
  logic              r_host_ack;
  logic              r_rd_zero;

  logic              w_req_oor;
  logic              w_host_oor;
  logic              w_host_go;
  logic              w_ram_we;
  logic              w_ram_re;
  logic [c_idx_w-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdata;
  logic [DATA_W-1:0] w_ram_q;

  assign w_req_oor  = ({1'b0, r_addr} >= c_depth);
  assign w_host_oor = ({1'b0, host_addr} >= c_depth);
  assign w_host_go  = (r_state == ST_IDLE) && (mem_cmd == MEM_IDLE) && host_we;

  // Single RAM port: the latched request owns it in ACCESS, the host only in an idle IDLE cycle.
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_re    = 1'b0;
    w_ram_addr  = host_addr[c_idx_w-1:0];
    w_ram_wdata = host_wdata;
    if (r_state == ST_ACCESS) begin
      w_ram_addr  = r_addr[c_idx_w-1:0];
      w_ram_wdata = r_wdata;
      w_ram_we    = !rst && !w_req_oor && (r_cmd == MEM_WRITE);
      w_ram_re    = !rst && !w_req_oor && (r_cmd != MEM_WRITE);
    end else if (w_host_go) begin
      w_ram_we    = !rst && !w_host_oor;
    end
  end

  sp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (c_idx_w)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (w_ram_we),
    .re    (w_ram_re),
    .addr  (w_ram_addr),
    .wdata (w_ram_wdata),
    .q     (w_ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cmd      <= MEM_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wait_cnt <= '0;
      r_rvalid   <= 1'b0;
      r_is_fetch <= 1'b0;
      r_wdone    <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_host_ack <= 1'b0;
      r_rd_zero  <= 1'b0;
    end else begin
      r_rvalid   <= 1'b0;
      r_is_fetch <= 1'b0;
      r_wdone    <= 1'b0;
      r_err      <= 1'b0;
      r_host_ack <= 1'b0;
      case (r_state)
        // RESP accepts a new command exactly like IDLE, giving back-to-back service.
        ST_IDLE, ST_RESP: begin
          if (is_mem_op(mem_cmd)) begin
            r_cmd      <= mem_cmd;
            r_addr     <= addr;
            r_wdata    <= wdata;
            r_wait_cnt <= c_wait_load;
            r_busy     <= 1'b1;
            r_state    <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
            if (mem_cmd != MEM_IDLE) begin
              r_err <= 1'b1;
            end else if (w_host_go) begin
              r_host_ack <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (r_wait_cnt == 4'd0) begin
            r_state <= ST_ACCESS;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        ST_ACCESS: begin
          r_state <= ST_RESP;
          r_busy  <= 1'b0;
          r_err   <= w_req_oor;
          if (r_cmd == MEM_WRITE) begin
            r_wdone <= 1'b1;
          end else begin
            r_rvalid   <= 1'b1;
            r_is_fetch <= (r_cmd == MEM_FETCH);
            r_rd_zero  <= w_req_oor;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // An out-of-range read masks the RAM register to zero until the next in-range read.
  assign rdata    = r_rd_zero ? '0 : w_ram_q;
  assign rvalid   = r_rvalid;
  assign is_fetch = r_is_fetch;
  assign wdone    = r_wdone;
  assign busy     = r_busy;
  assign err      = r_err;
  assign host_ack = r_host_ack;

endmodule
`default_nettype wire
